// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-and-add multiplier. One ripple-adder pass per
// cycle; the 2N-bit product appears after N iterations and is then held in p.

module fulladderNb #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];
endmodule

module shift_add_multiplier #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [N-1:0]  m;
    logic [N-1:0]  q;
    logic [N-1:0]  acc;
    logic [CW-1:0] count;
    logic [N-1:0]  addend;
    logic [N-1:0]  s;
    logic          cout;

    assign addend = q[0] ? m : '0;

    fulladderNb #(.N(N)) u_add (
        .a   (acc),
        .b   (addend),
        .cin (1'b0),
        .s   (s),
        .cout(cout)
    );

    // The adder carry-out is shifted straight into acc's MSB each iteration, so
    // the carry position above acc always receives 0 and needs no flop of its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        count <= '0;
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= {cout, s[N-1:1]};
                    q     <= {s[0], q[N-1:1]};
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        p     <= {cout, s[N-1:1], s[0], q[N-1:1]};
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: N=4 exhaustive plus N=8 samples,
// streaming start, operand changes while busy and asynchronous reset abort.

module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start4 = 1'b0, start8 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4)
    );

    shift_add_multiplier #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One full operation on dut4 (sel=0) or dut8 (sel=1), checking timing and result.
    task automatic run_op(input int sel, input logic [7:0] x, input logic [7:0] y);
        int          nn;
        int          done_cnt;
        int          busy_cnt;
        int          done_at;
        logic [15:0] expv;
        logic        dn, bs;
        logic [15:0] pv;
        nn       = (sel != 0) ? 8 : 4;
        expv     = 16'(x) * 16'(y);
        done_cnt = 0;
        busy_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        if (sel != 0) begin a8 = x; b8 = y; start8 = 1'b1; end
        else begin a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1; end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        for (int i = 0; i <= nn + 1; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            dn = (sel != 0) ? done8 : done4;
            bs = (sel != 0) ? busy8 : busy4;
            pv = (sel != 0) ? p8 : {8'h00, p4};
            if (dn) begin
                done_cnt++;
                done_at = i;
                check("p_at_done", 64'(pv), 64'(expv));
            end
            if (bs) busy_cnt++;
        end
        pv = (sel != 0) ? p8 : {8'h00, p4};
        check("done_cycle", 64'(done_at), 64'(nn));
        check("done_width", 64'(done_cnt), 64'd1);
        check("busy_cycles", 64'(busy_cnt), 64'(nn + 1));
        check("p_hold", 64'(pv), 64'(expv));
    endtask

    initial begin
        int got_done;
        int ra, rb;

        // Reset state
        #12;
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_done4", 64'(done4), 64'd0);
        check("rst_p4", 64'(p4), 64'd0);
        check("rst_p8", 64'(p8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed products
        run_op(0, 8'd13, 8'd11);
        check("p_13x11", 64'(p4), 64'h8F);
        run_op(0, 8'd15, 8'd15);
        check("p_15x15", 64'(p4), 64'hE1);
        run_op(0, 8'd0, 8'd9);
        run_op(0, 8'd1, 8'd15);

        // Start held high: back-to-back operations every N+2 cycles
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
        @(posedge clk);
        #1;
        check("stream_busy0", 64'(busy4), 64'd1);
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd6;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                check("stream_done1", 64'(done4), 64'd1);
                check("stream_p1", 64'(p4), 64'd15);
            end
            if (i == 5) check("stream_idle", 64'(busy4), 64'd0);
            if (i == 6) check("stream_busy2", 64'(busy4), 64'd1);
        end
        start4 = 1'b0;
        for (int i = 7; i <= 11; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) begin
                check("stream_done2", 64'(done4), 64'd1);
                check("stream_p2", 64'(p4), 64'd42);
            end
            if (i == 11) check("stream_end", 64'(busy4), 64'd0);
        end

        // start and operands toggled during CALC and DONE are ignored
        @(negedge clk);
        a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'd2; b4 = 4'd2; start4 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                check("ign_done", 64'(done4), 64'd1);
                check("ign_p", 64'(p4), 64'd143);
                @(negedge clk);
                start4 = 1'b0;
            end
            if (i == 3) check("ign_no_early", 64'(done4), 64'd0);
            if (i == 5) check("ign_idle", 64'(busy4), 64'd0);
        end

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy4), 64'd0);
        check("arst_done", 64'(done4), 64'd0);
        check("arst_p", 64'(p4), 64'd0);
        got_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done4) got_done++;
            if (i == 2) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        check("arst_no_done", 64'(got_done), 64'd0);
        run_op(0, 8'd6, 8'd7);
        check("arst_p42", 64'(p4), 64'd42);

        // Exhaustive N=4 sweep
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run_op(0, 8'(x), 8'(y));

        // N=8 corner and random sample
        run_op(1, 8'd255, 8'd255);
        check("p8_max", 64'(p8), 64'd65025);
        run_op(1, 8'd0, 8'd200);
        for (int k = 0; k < 24; k++) begin
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            run_op(1, 8'(ra), 8'(rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
